fxp_mul_seq: RTL and testbench

Sequential signed-magnitude Q7.8 fixed-point multiplier. It is the multiplicative counterpart of the ALU's combinational divider and uses the same operand and result word format and the same flag set. It computes the product with a radix-2 shift-add over 15 cycles behind a start/done handshake. It sits beside the other ALU functional units and is selected by the execute stage for multiply ops.

---
 rtl/fxp_pkg.sv | 16 +
 rtl/fxp_mul_seq.sv | 129 ++++++++++++
 tb/tb_fxp_mul_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared Q7.8 signed-magnitude constants and FSM state type
package fxp_pkg;

    localparam int FXP_FRAC_BITS = 8;
    localparam int FXP_MAG_BITS  = 15;
    localparam int FXP_SIGN_BIT  = 15;
    localparam int FXP_ITERS     = 15;
    localparam int FXP_ACC_BITS  = 2 * FXP_MAG_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fxp_state_e;

endpackage

// File: rtl/fxp_mul_seq.sv
// rtl/fxp_mul_seq.sv - sequential Q7.8 signed-magnitude shift-add multiplier
module fxp_mul_seq
    import fxp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] c,
    output logic         cout,
    output logic         zero,
    output logic         overflow,
    output logic         neg
);

    localparam int PW = FXP_ACC_BITS - FXP_FRAC_BITS;

    fxp_state_e              state_q, state_d;
    logic [FXP_MAG_BITS-1:0] a_q, a_d;
    logic [FXP_MAG_BITS-1:0] b_q, b_d;
    logic                    s_q, s_d;
    logic [FXP_ACC_BITS-1:0] acc_q, acc_d;
    logic [3:0]              iter_q, iter_d;
    logic [15:0]             c_q, c_d;
    logic                    cout_q, cout_d;
    logic                    zero_q, zero_d;
    logic                    ovf_q, ovf_d;

    logic [FXP_ACC_BITS-1:0] acc_sum;
    logic [PW-1:0]           prod;
    logic                    res_zero;

    generate
        if (N > 16) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{a[N-1:16], b[N-1:16]};
        end
    endgenerate

    // The partial product for this iteration; also feeds the result path on the last one.
    always_comb begin
        acc_sum  = acc_q + (b_q[iter_q] ? ({{FXP_MAG_BITS{1'b0}}, a_q} << iter_q)
                                        : {FXP_ACC_BITS{1'b0}});
        prod     = acc_sum[FXP_ACC_BITS-1:FXP_FRAC_BITS];
        res_zero = (prod[FXP_MAG_BITS-1:0] == '0);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        c_d     = c_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a[FXP_MAG_BITS-1:0];
                    b_d     = b[FXP_MAG_BITS-1:0];
                    s_d     = a[FXP_SIGN_BIT] ^ b[FXP_SIGN_BIT];
                    acc_d   = '0;
                    iter_d  = '0;
                end
            end
            RUN: begin
                acc_d  = acc_sum;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(FXP_ITERS - 1)) begin
                    state_d = DONE;
                    c_d     = {s_q & ~res_zero, prod[FXP_MAG_BITS-1:0]};
                    cout_d  = prod[FXP_MAG_BITS];
                    zero_d  = res_zero;
                    ovf_d   = |prod[PW-1:FXP_MAG_BITS];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= 1'b0;
            acc_q   <= '0;
            iter_q  <= '0;
            c_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        c        = '0;
        c[15:0]  = c_q;
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        cout     = cout_q;
        zero     = zero_q;
        overflow = ovf_q;
        neg      = c_q[FXP_SIGN_BIT];
    end

endmodule

// File: tb/tb_fxp_mul_seq.sv
// tb/tb_fxp_mul_seq.sv - directed-vector bench for fxp_mul_seq
module tb_fxp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, cout, zero, overflow, neg;
    logic [31:0] c;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    fxp_mul_seq #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .c        (c),
        .cout     (cout),
        .zero     (zero),
        .overflow (overflow),
        .neg      (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [31:0] ec, input logic ecout,
                              input logic ezero, input logic eovf, input logic eneg);
        chk({tag, ".c"}, c, ec);
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ecout});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ezero});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eovf});
        chk({tag, ".neg"}, {31'd0, neg}, {31'd0, eneg});
    endtask

    // Start one op at a negedge, scramble operands afterwards, time done and busy.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] ec, input logic ecout, input logic ezero,
                          input logic eovf, input logic eneg);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a = {16'hA5C3, av};
        b = {16'h3C5A, bv};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 16);
        chk({tag, ".busy_cycles"}, busy_cnt, 15);
        chk_result(tag, ec, ecout, ezero, eovf, eneg);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int first_done;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk_result("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run_op("basic", 16'h0180, 16'h0200, 32'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sign",  16'h8180, 16'h0200, 32'h8300, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("trunc", 16'h0001, 16'h0080, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("negz",  16'h0000, 16'h8300, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("ovf1",  16'h4000, 16'h0200, 32'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("ovf2",  16'h4000, 16'h0400, 32'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("negneg", 16'h8280, 16'h8100, 32'h0280, 1'b0, 1'b0, 1'b0, 1'b0);

        // Extra start pulse during RUN must be ignored.
        @(negedge clk);
        a = 32'h0000_0180;
        b = 32'h0000_0200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        first_done = 0;
        for (int i = 1; i < 40; i++) begin
            if (i == 5) begin
                a = 32'h0000_0100;
                b = 32'h0000_0100;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
            @(negedge clk);
        end
        chk("ignore.done_count", done_cnt, 1);
        chk("ignore.done_cycle", first_done, 16);
        chk("ignore.c", c, 32'h0300);

        // Start held high through DONE launches the next op back to back.
        @(negedge clk);
        a = 32'h0000_8180;
        b = 32'h0000_0200;
        start = 1'b1;
        @(negedge clk);
        a = 32'h0000_0100;
        b = 32'h0000_0300;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.first_cycle", cyc, 16);
        chk("b2b.first_c", c, 32'h8300);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.second_cycle", cyc, 32);
        chk_result("b2b.second", 32'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("b2b.idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN aborts with no done.
        a = 32'h0000_0180;
        b = 32'h0000_0200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 7; i++) @(negedge clk);
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk_result("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        chk("abort.no_activity", done_cnt, 0);

        run_op("fresh", 16'h0100, 16'h0300, 32'h0300, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
